// File: rtl/xgs_hispi_tx_pkg.sv
// ============================================================================
// Module      : xgs_hispi_tx_pkg
// Description : Shared constants for the HiSPi Packetized-SP lane transmitter:
//               FSM state encodings, sync header words and sync codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package xgs_hispi_tx_pkg;

    // FSM state encodings
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SYNC_S = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_SYNC_E = 3'd3;
    localparam logic [2:0] c_ST_BLANK  = 3'd4;

    // Sync codes, carried in the low nibble of the fourth sync word
    localparam logic [3:0] c_CODE_SOL = 4'h1;
    localparam logic [3:0] c_CODE_SOF = 4'h3;
    localparam logic [3:0] c_CODE_EOL = 4'h5;
    localparam logic [3:0] c_CODE_EOF = 4'h7;

    // Index of the sync word that carries the code
    localparam logic [1:0] c_SYNC_LAST = 2'd3;

endpackage

`default_nettype wire

// File: rtl/xgs_hispi_lane_tx.sv
// ============================================================================
// Module      : xgs_hispi_lane_tx
// Description : Single-lane HiSPi Packetized-SP word generator. Frames a pixel
//               stream into lines (start sync, payload, end sync, blanking)
//               and emits one registered word per word_ce strobe.
// Ports       : sclk/sclk_reset        clock, synchronous active-high reset
//               enable                 allow new lines to start
//               word_ce                serializer word strobe
//               s_valid/s_ready/s_data pixel stream handshake
//               s_sol/s_eol/s_sof/s_eof line/frame markers
//               tx_word/tx_sync        word to serializer, sync-word flag
//               busy                   FSM not idle
//               underrun/proto_err     sticky error flags, cleared by err_clr
//               line_cnt/frame_cnt     completed lines / EOF syncs sent
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xgs_hispi_lane_tx
    import xgs_hispi_tx_pkg::*;
#(
    parameter int               PIX_W          = 12,
    parameter int               LINE_BLANK_MIN = 8,
    parameter logic [PIX_W-1:0] IDLE_WORD      = 12'h3A6
) (
    input  logic             sclk,
    input  logic             sclk_reset,
    input  logic             enable,
    input  logic             word_ce,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_sol,
    input  logic             s_eol,
    input  logic             s_sof,
    input  logic             s_eof,
    output logic [PIX_W-1:0] tx_word,
    output logic             tx_sync,
    output logic             busy,
    output logic             underrun,
    output logic             proto_err,
    input  logic             err_clr,
    output logic [15:0]      line_cnt,
    output logic [15:0]      frame_cnt
);

    localparam int c_BW = (LINE_BLANK_MIN > 1) ? $clog2(LINE_BLANK_MIN) : 1;
    localparam logic [c_BW-1:0] c_BLANK_LAST = c_BW'(LINE_BLANK_MIN - 1);

    logic [2:0]       r_state;
    logic [1:0]       r_idx;
    logic [c_BW-1:0]  r_blank;
    logic [3:0]       r_code;
    logic             r_eof_pend;
    logic [PIX_W-1:0] r_tx_word;
    logic             r_tx_sync;
    logic             r_underrun;
    logic             r_proto_err;
    logic [15:0]      r_line_cnt;
    logic [15:0]      r_frame_cnt;

    logic             w_in_idle;
    logic             w_in_data;
    logic [PIX_W-1:0] w_sync_word;

    assign w_in_idle = (r_state == c_ST_IDLE);
    assign w_in_data = (r_state == c_ST_DATA);

    // DATA accepts on every strobe (an absent beat becomes an underrun idle);
    // IDLE only consumes stray beats, the SOL beat is peeked and left in place.
    assign s_ready = word_ce & (w_in_data | (w_in_idle & s_valid & ~s_sol));

    // Sync header FFF,000,000,code shared by start and end syncs
    always_comb begin
        w_sync_word = '0;
        if (r_idx == 2'd0) begin
            w_sync_word = '1;
        end else if (r_idx == c_SYNC_LAST) begin
            w_sync_word = {{(PIX_W-4){1'b0}}, r_code};
        end
    end

    always_ff @(posedge sclk) begin
        if (sclk_reset) begin
            r_state     <= c_ST_IDLE;
            r_idx       <= 2'd0;
            r_blank     <= '0;
            r_code      <= c_CODE_SOL;
            r_eof_pend  <= 1'b0;
            r_tx_word   <= IDLE_WORD;
            r_tx_sync   <= 1'b0;
            r_underrun  <= 1'b0;
            r_proto_err <= 1'b0;
            r_line_cnt  <= 16'd0;
            r_frame_cnt <= 16'd0;
        end else begin
            // Clear first so a set later in this block takes priority
            if (err_clr) begin
                r_underrun  <= 1'b0;
                r_proto_err <= 1'b0;
            end

            if (word_ce) begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_tx_word <= IDLE_WORD;
                        r_tx_sync <= 1'b0;
                        if (s_valid) begin
                            if (s_sol) begin
                                if (enable) begin
                                    r_state    <= c_ST_SYNC_S;
                                    r_idx      <= 2'd0;
                                    r_code     <= s_sof ? c_CODE_SOF : c_CODE_SOL;
                                    r_eof_pend <= s_eof;
                                end
                            end else begin
                                r_proto_err <= 1'b1;
                            end
                        end
                    end

                    c_ST_SYNC_S: begin
                        r_tx_word <= w_sync_word;
                        r_tx_sync <= 1'b1;
                        r_idx     <= r_idx + 2'd1;
                        if (r_idx == c_SYNC_LAST) begin
                            r_state <= c_ST_DATA;
                        end
                    end

                    c_ST_DATA: begin
                        r_tx_sync <= 1'b0;
                        if (s_valid) begin
                            r_tx_word <= s_data;
                            if (s_eol) begin
                                r_state <= c_ST_SYNC_E;
                                r_idx   <= 2'd0;
                                r_code  <= r_eof_pend ? c_CODE_EOF : c_CODE_EOL;
                            end
                        end else begin
                            r_tx_word  <= IDLE_WORD;
                            r_underrun <= 1'b1;
                        end
                    end

                    c_ST_SYNC_E: begin
                        r_tx_word <= w_sync_word;
                        r_tx_sync <= 1'b1;
                        r_idx     <= r_idx + 2'd1;
                        if (r_idx == c_SYNC_LAST) begin
                            r_state    <= c_ST_BLANK;
                            r_blank    <= '0;
                            r_line_cnt <= r_line_cnt + 16'd1;
                            if (r_eof_pend) begin
                                r_frame_cnt <= r_frame_cnt + 16'd1;
                            end
                        end
                    end

                    c_ST_BLANK: begin
                        r_tx_word <= IDLE_WORD;
                        r_tx_sync <= 1'b0;
                        r_blank   <= r_blank + c_BW'(1);
                        if (r_blank == c_BLANK_LAST) begin
                            r_state <= c_ST_IDLE;
                        end
                    end

                    default: begin
                        r_state   <= c_ST_IDLE;
                        r_tx_word <= IDLE_WORD;
                        r_tx_sync <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_word   = r_tx_word;
    assign tx_sync   = r_tx_sync;
    assign busy      = ~w_in_idle;
    assign underrun  = r_underrun;
    assign proto_err = r_proto_err;
    assign line_cnt  = r_line_cnt;
    assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_xgs_hispi_lane_tx.sv
// ============================================================================
// Module      : tb_xgs_hispi_lane_tx
// Description : Self-checking bench for xgs_hispi_lane_tx. A line-level model
//               predicts every emitted word, flag and counter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_xgs_hispi_lane_tx;

    localparam int          PIX_W  = 12;
    localparam int          BLANK  = 8;
    localparam logic [11:0] IDLE_W = 12'h3A6;

    logic        sclk = 1'b0;
    logic        sclk_reset;
    logic        enable;
    logic        word_ce;
    logic        s_valid;
    logic        s_ready;
    logic [11:0] s_data;
    logic        s_sol, s_eol, s_sof, s_eof;
    logic [11:0] tx_word;
    logic        tx_sync;
    logic        busy;
    logic        underrun;
    logic        proto_err;
    logic        err_clr;
    logic [15:0] line_cnt;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [15:0] m_lines  = 16'd0;
    logic [15:0] m_frames = 16'd0;
    logic        m_under  = 1'b0;
    logic        m_proto  = 1'b0;
    logic [11:0] m_last   = IDLE_W;
    int          gap_fixed = 0;   // >=0: fixed idle sclks between strobes
    int          max_gap   = 0;   // random idle sclks when gap_fixed < 0

    always #5 sclk = ~sclk;

    xgs_hispi_lane_tx #(
        .PIX_W         (PIX_W),
        .LINE_BLANK_MIN(BLANK),
        .IDLE_WORD     (IDLE_W)
    ) dut (
        .sclk      (sclk),
        .sclk_reset(sclk_reset),
        .enable    (enable),
        .word_ce   (word_ce),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_sol     (s_sol),
        .s_eol     (s_eol),
        .s_sof     (s_sof),
        .s_eof     (s_eof),
        .tx_word   (tx_word),
        .tx_sync   (tx_sync),
        .busy      (busy),
        .underrun  (underrun),
        .proto_err (proto_err),
        .err_clr   (err_clr),
        .line_cnt  (line_cnt),
        .frame_cnt (frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sync header as seen on the wire: FFF, 000, 000, code
    function automatic logic [11:0] hdr(input int k, input logic [11:0] code);
        if (k == 0) return 12'hFFF;
        if (k == 3) return code;
        return 12'h000;
    endfunction

    task automatic apply(input logic v, input logic [11:0] d,
                         input logic sol, input logic eol, input logic sof, input logic eof);
        s_valid = v; s_data = d; s_sol = sol; s_eol = eol; s_sof = sof; s_eof = eof;
    endtask

    // One word strobe (preceded by idle sclks); checks handshake and output word
    task automatic step(input logic v, input logic [11:0] d,
                        input logic sol, input logic eol, input logic sof, input logic eof,
                        input logic [11:0] exp_w, input logic exp_s, input logic exp_r,
                        input string tag);
        int gaps;
        gaps = (gap_fixed >= 0) ? gap_fixed : int'($urandom_range(max_gap, 0));
        for (int g = 0; g < gaps; g++) begin
            @(negedge sclk);
            word_ce = 1'b0;
            apply(v, d, sol, eol, sof, eof);
            #1 chk({tag, "/ready_hold"}, 32'(s_ready), 32'd0);
            @(posedge sclk);
            #1 chk({tag, "/word_hold"}, 32'(tx_word), 32'(m_last));
        end
        @(negedge sclk);
        word_ce = 1'b1;
        apply(v, d, sol, eol, sof, eof);
        #1 chk({tag, "/ready"}, 32'(s_ready), 32'(exp_r));
        @(posedge sclk);
        #1;
        chk({tag, "/word"}, 32'(tx_word), 32'(exp_w));
        chk({tag, "/sync"}, 32'(tx_sync), 32'(exp_s));
        m_last = exp_w;
    endtask

    task automatic quiet();
        @(negedge sclk);
        word_ce = 1'b0;
        apply(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "/line_cnt"}, 32'(line_cnt), 32'(m_lines));
        chk({tag, "/frame_cnt"}, 32'(frame_cnt), 32'(m_frames));
        chk({tag, "/underrun"}, 32'(underrun), 32'(m_under));
        chk({tag, "/proto_err"}, 32'(proto_err), 32'(m_proto));
    endtask

    // One complete line. base>=0 gives pixels base+i, else random.
    // abort_at>=0 resets the DUT after that many payload words.
    // drop_en_at>=0 lowers enable after that many payload words.
    task automatic send_line(input int n, input logic sof, input logic eof, input int base,
                             input int gap_pct, input int abort_at, input int drop_en_at,
                             input string tag);
        logic [11:0] pix[$];
        logic [11:0] c_start, c_end;
        logic        probe;
        int          i;
        for (int k = 0; k < n; k++)
            pix.push_back((base >= 0) ? 12'(base + k) : 12'($urandom));
        c_start = sof ? 12'h003 : 12'h001;
        c_end   = eof ? 12'h007 : 12'h005;

        step(1'b1, pix[0], 1'b1, n == 1, sof, eof, IDLE_W, 1'b0, 1'b0, {tag, "/peek"});
        for (int k = 0; k < 4; k++)
            step(1'b1, pix[0], 1'b1, n == 1, sof, eof, hdr(k, c_start), 1'b1, 1'b0, {tag, "/sync_s"});
        chk({tag, "/busy"}, 32'(busy), 32'd1);

        i = 0;
        while (i < n) begin
            if (abort_at >= 0 && i == abort_at) begin
                @(negedge sclk);
                word_ce = 1'b0;
                sclk_reset = 1'b1;
                @(posedge sclk);
                #1;
                m_lines = 16'd0; m_frames = 16'd0; m_under = 1'b0; m_proto = 1'b0;
                m_last = IDLE_W;
                chk({tag, "/rst_word"}, 32'(tx_word), 32'(IDLE_W));
                chk({tag, "/rst_sync"}, 32'(tx_sync), 32'd0);
                chk({tag, "/rst_busy"}, 32'(busy), 32'd0);
                check_status({tag, "/rst"});
                @(negedge sclk);
                sclk_reset = 1'b0;
                return;
            end
            if (drop_en_at >= 0 && i == drop_en_at) enable = 1'b0;
            if (int'($urandom_range(99, 0)) < gap_pct) begin
                step(1'b0, 12'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, IDLE_W, 1'b0, 1'b1, {tag, "/gap"});
                m_under = 1'b1;
            end else begin
                // SOL inside the payload is plain data
                step(1'b1, pix[i], (i == 0) ? 1'b1 : 1'($urandom), i == n - 1, 1'($urandom),
                     1'($urandom), pix[i], 1'b0, 1'b1, {tag, "/data"});
                i++;
            end
        end

        for (int k = 0; k < 4; k++)
            step(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, hdr(k, c_end), 1'b1, 1'b0, {tag, "/sync_e"});
        m_lines = m_lines + 16'd1;
        if (eof) m_frames = m_frames + 16'd1;

        // A waiting SOL beat must not be taken during blanking
        probe = 1'($urandom);
        for (int b = 0; b < BLANK; b++)
            step(probe, 12'($urandom), 1'b1, 1'b0, 1'b1, 1'b0, IDLE_W, 1'b0, 1'b0, {tag, "/blank"});
        chk({tag, "/busy_end"}, 32'(busy), 32'd0);
        check_status(tag);
    endtask

    task automatic clear_errors(input string tag);
        @(negedge sclk);
        word_ce = 1'b0;
        err_clr = 1'b1;
        @(negedge sclk);
        err_clr = 1'b0;
        m_under = 1'b0;
        m_proto = 1'b0;
        chk({tag, "/underrun"}, 32'(underrun), 32'd0);
        chk({tag, "/proto_err"}, 32'(proto_err), 32'd0);
    endtask

    initial begin
        sclk_reset = 1'b1;
        enable     = 1'b1;
        word_ce    = 1'b0;
        err_clr    = 1'b0;
        apply(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge sclk);
        #1;
        chk("reset/word", 32'(tx_word), 32'(IDLE_W));
        chk("reset/sync", 32'(tx_sync), 32'd0);
        chk("reset/ready", 32'(s_ready), 32'd0);
        chk("reset/busy", 32'(busy), 32'd0);
        check_status("reset");
        @(negedge sclk);
        sclk_reset = 1'b0;

        // 1: SOF+EOF line 0x010..0x013, strobe every sclk
        gap_fixed = 0;
        send_line(4, 1'b1, 1'b1, 12'h010, 0, -1, -1, "t1");

        // 2: 3-line frame, strobe every 3rd sclk
        gap_fixed = 2;
        send_line(3, 1'b1, 1'b0, -1, 0, -1, -1, "t2a");
        send_line(5, 1'b0, 1'b0, -1, 0, -1, -1, "t2b");
        send_line(2, 1'b0, 1'b1, -1, 0, -1, -1, "t2c");

        // 3: payload gaps set underrun; err_clr clears it
        gap_fixed = 0;
        send_line(6, 1'b0, 1'b0, -1, 35, -1, -1, "t3");
        clear_errors("t3_clr");

        // 4: beat without SOL in IDLE is consumed and flagged
        step(1'b1, 12'h123, 1'b0, 1'b0, 1'b0, 1'b0, IDLE_W, 1'b0, 1'b1, "t4/beat");
        m_proto = 1'b1;
        for (int k = 0; k < 5; k++)
            step(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, IDLE_W, 1'b0, 1'b0, "t4/after");
        chk("t4/busy", 32'(busy), 32'd0);
        check_status("t4");
        clear_errors("t4_clr");

        // Randomized lines, random strobe spacing and payload gaps
        gap_fixed = -1;
        max_gap   = 2;
        for (int l = 0; l < 12; l++)
            send_line(int'($urandom_range(6, 1)), 1'($urandom), 1'($urandom), -1, 15, -1, -1, "rnd");
        send_line(1, 1'b1, 1'b1, -1, 0, -1, -1, "single");

        // 5: reset after 2 payload words
        gap_fixed = 0;
        send_line(5, 1'b1, 1'b0, -1, 0, 2, -1, "t5");

        // 6: line_cnt wrap, and enable dropped mid-line
        quiet();
        force dut.r_line_cnt = 16'hFFFF;
        @(negedge sclk);
        release dut.r_line_cnt;
        m_lines = 16'hFFFF;
        @(negedge sclk);
        chk("t6/preload", 32'(line_cnt), 32'hFFFF);
        send_line(4, 1'b0, 1'b1, -1, 0, -1, 1, "t6");
        for (int k = 0; k < 3; k++)
            step(1'b1, 12'h055, 1'b1, 1'b0, 1'b1, 1'b0, IDLE_W, 1'b0, 1'b0, "t6/en_off");
        chk("t6/idle", 32'(busy), 32'd0);
        enable = 1'b1;
        send_line(2, 1'b1, 1'b1, -1, 0, -1, -1, "t6_resume");

        quiet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound on run time
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
